// File: rtl/cv32e40px_popcnt_pkg.sv
// Shared types and elaboration helpers for the pipelined population-count unit.
//   popcnt_sb_t       : sideband carried next to the partial counts (valid, accum, last)
//   num_levels        : number of pairwise adder levels for a given operand width
//   stage_level       : tree level after which pipeline register s is placed
//   stage_after_level : 1 when some pipeline register sits after the given level
//   stages_collide    : 1 when two pipeline registers would land after the same level
package cv32e40px_popcnt_pkg;

  typedef struct packed {
    logic valid;
    logic accum;
    logic last;
  } popcnt_sb_t;

  function automatic int unsigned num_levels(input int unsigned width);
    return $clog2(width);
  endfunction

  // round((s+1)*levels/(pipe_stages+1)), rounding halves upwards
  function automatic int unsigned stage_level(input int unsigned pipe_stages,
                                              input int unsigned levels,
                                              input int unsigned s);
    return (2 * (s + 1) * levels + pipe_stages + 1) / (2 * (pipe_stages + 1));
  endfunction

  function automatic bit stage_after_level(input int unsigned pipe_stages,
                                           input int unsigned levels,
                                           input int unsigned level);
    bit hit = 1'b0;
    for (int unsigned s = 0; s < pipe_stages; s++) begin
      if (stage_level(pipe_stages, levels, s) == level) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic bit stages_collide(input int unsigned pipe_stages,
                                        input int unsigned levels);
    bit dup = 1'b0;
    for (int unsigned s = 1; s < pipe_stages; s++) begin
      if (stage_level(pipe_stages, levels, s) == stage_level(pipe_stages, levels, s - 1)) begin
        dup = 1'b1;
      end
    end
    return dup;
  endfunction

endpackage

// File: rtl/cv32e40px_popcnt_level.sv
// One level of the popcount adder tree: adds adjacent pairs of IN_W-bit counts.
//   in_i  : N_IN counts of IN_W bits, count j at bits [j*IN_W +: IN_W]
//   out_o : N_IN/2 counts of IN_W+1 bits, same packing
// Purely combinational.
module cv32e40px_popcnt_level #(
  parameter int unsigned IN_W = 1,
  parameter int unsigned N_IN = 2
) (
  input  logic [N_IN*IN_W-1:0]         in_i,
  output logic [(N_IN/2)*(IN_W+1)-1:0] out_o
);

  for (genvar j = 0; j < N_IN / 2; j++) begin : g_pair
    assign out_o[j*(IN_W+1) +: IN_W+1] = (IN_W+1)'(in_i[2*j*IN_W +: IN_W])
                                       + (IN_W+1)'(in_i[(2*j+1)*IN_W +: IN_W]);
  end

endmodule

// File: rtl/cv32e40px_popcnt_pipe.sv
// Pipelined population count with optional multi-beat saturating accumulation.
//   clk, rst            : clock, synchronous active-high reset
//   valid_i / ready_o   : input beat handshake
//   data_i              : WIDTH-bit operand
//   accum_i / last_i    : beat is part of a group / closes the group
//   valid_o / ready_i   : result handshake
//   result_o            : bit count or saturated group sum
//   overflow_o          : group sum saturated at some point in the group
// The whole pipeline advances together whenever the output slot is free or being drained.
module cv32e40px_popcnt_pipe
  import cv32e40px_popcnt_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned ACC_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 accum_i,
  input  logic                 last_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ACC_WIDTH-1:0] result_o,
  output logic                 overflow_o
);

  localparam int unsigned L = num_levels(WIDTH);

  if (PIPE_STAGES > L || stages_collide(PIPE_STAGES, L) || ACC_WIDTH < L + 1) begin : g_param_err
    $error("cv32e40px_popcnt_pipe: illegal WIDTH/PIPE_STAGES/ACC_WIDTH combination");
  end

  logic en;
  logic valid_q, valid_d;
  logic ovf_q, ovf_d;
  logic gsat_q, gsat_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  assign en      = !valid_q || ready_i;
  assign ready_o = en;

  // Level k reads level k-1; the root (level L) is never registered here, it feeds the
  // output register directly.
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int unsigned NIn  = WIDTH >> (k - 1);
    localparam int unsigned OutW = (WIDTH >> k) * (k + 1);

    logic [NIn*k-1:0] in_cnt;
    popcnt_sb_t       in_sb;
    logic [OutW-1:0]  sum;
    logic [OutW-1:0]  cnt;
    popcnt_sb_t       sb;

    if (k == 1) begin : g_src_in
      assign in_cnt = data_i;
      assign in_sb  = '{valid: valid_i, accum: accum_i, last: last_i};
    end else begin : g_src_lvl
      assign in_cnt = g_lvl[k-1].cnt;
      assign in_sb  = g_lvl[k-1].sb;
    end

    cv32e40px_popcnt_level #(
      .IN_W (k),
      .N_IN (NIn)
    ) u_level (
      .in_i  (in_cnt),
      .out_o (sum)
    );

    if (k < L && stage_after_level(PIPE_STAGES, L, k)) begin : g_reg
      logic [OutW-1:0] sum_q;
      popcnt_sb_t      sb_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q <= '0;
          sb_q  <= '0;
        end else if (en) begin
          sum_q <= sum;
          sb_q  <= in_sb;
        end
      end

      assign cnt = sum_q;
      assign sb  = sb_q;
    end else begin : g_pass
      assign cnt = sum;
      assign sb  = in_sb;
    end
  end

  popcnt_sb_t           fin_sb;
  logic [ACC_WIDTH-1:0] cnt_fin;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;
  logic [ACC_WIDTH-1:0] sum_sat;

  assign fin_sb  = g_lvl[L].sb;
  assign cnt_fin = ACC_WIDTH'(g_lvl[L].cnt);

  always_comb begin
    sum_ext = {1'b0, acc_q} + {1'b0, cnt_fin};
    carry   = sum_ext[ACC_WIDTH];
    sum_sat = carry ? '1 : sum_ext[ACC_WIDTH-1:0];
  end

  // Single beats bypass the accumulator entirely, so they may sit inside an open group.
  always_comb begin
    valid_d  = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    gsat_d   = gsat_q;
    if (fin_sb.valid) begin
      if (!fin_sb.accum) begin
        valid_d  = 1'b1;
        result_d = cnt_fin;
        ovf_d    = 1'b0;
      end else if (!fin_sb.last) begin
        acc_d  = sum_sat;
        gsat_d = gsat_q | carry;
      end else begin
        valid_d  = 1'b1;
        result_d = sum_sat;
        ovf_d    = gsat_q | carry;
        acc_d    = '0;
        gsat_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      gsat_q   <= 1'b0;
    end else if (en) begin
      valid_q  <= valid_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      gsat_q   <= gsat_d;
    end
  end

  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/cv32e40px_popcnt_pipe.md
Name: cv32e40px_popcnt_pipe

Overview:
Parametrised, pipelined population-count unit for bit-manipulation and vector-reduction use in the EX stage and accelerators.
- Counts the '1' bits of a WIDTH-bit operand through a balanced adder tree.
- Optional pipeline registers are placed inside the tree.
- Adds a multi-beat accumulate mode: counts from consecutive beats are summed into one saturating result.
- valid/ready handshake on both sides; the whole pipeline stalls together.

Parameters:
WIDTH, 32, operand width; power of 2, 2..1024.
PIPE_STAGES, 2, register stages inside the tree; 0..log2(WIDTH).
ACC_WIDTH, 16, result/accumulator width; must be >= log2(WIDTH)+1.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_i  input  1  input beat valid
ready_o  output  1  unit can accept a beat
data_i  input  WIDTH  operand
accum_i  input  1  beat belongs to an accumulation group
last_i  input  1  closes the group; ignored when accum_i=0
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
result_o  output  ACC_WIDTH  bit count, or group sum
overflow_o  output  1  group sum saturated; qualified by valid_o

Behaviour:
- Interface: one clock domain; rst is synchronous and active-high.
- Reset values: valid_o=0, result_o=0, overflow_o=0; accumulator=0, group_sat=0, all stage valids=0. ready_o=1 in the first cycle after reset.
- Tree: level k adds adjacent pairs from level k-1, output width k+1. Level count L=log2(WIDTH); L-1 feeds the final block.
- Register placement: PIPE_STAGES registers after levels round((s+1)*L/(PIPE_STAGES+1)), s=0..PIPE_STAGES-1. Duplicate levels are not allowed (elaboration assert).
- Sideband: each stage carries valid, accum and last alongside the partial counts.
- Final stage: a combinational tree root, then one output register (result/valid/overflow).
- Latency: accept at cycle t gives valid_o at cycle t+PIPE_STAGES+1 with no stall. Throughput is 1 beat/cycle.
- Stall: en = !valid_o || ready_i.
  - ready_o = en.
  - All stage registers and the accumulator update only when en=1.
  - Bubbles (valid=0) move through when en=1; there is no per-stage compaction.
- Output hold: while valid_o && !ready_i, result_o and overflow_o are held stable.
- Final-stage actions when en=1 and the final beat is valid, with cnt = tree count:
  - accum=0: result_o<=cnt, overflow_o<=0, valid_o<=1. Accumulator and group_sat are untouched, so a single beat inside an open group is legal.
  - accum=1, last=0: accumulator<=sat(acc+cnt); group_sat |= carry-out; valid_o<=0 (no output).
  - accum=1, last=1: result_o<=sat(acc+cnt); overflow_o<=group_sat|carry; valid_o<=1; accumulator<=0; group_sat<=0.
- If en=1 and no valid final beat: valid_o<=0.
- Saturation: sums clamp at 2^ACC_WIDTH-1. overflow_o is sticky for the whole group.
- Count width: zero-extended to ACC_WIDTH.
  - data all-ones gives WIDTH.
  - data zero gives 0.
  - A group of only zeros gives 0 with overflow 0.
- Reset mid-group or mid-pipeline: all in-flight beats and the partial sum are discarded; nothing is emitted afterwards.
- Inputs are sampled only when valid_i && ready_o. data_i and sideband are don't-care otherwise.

Decomposition:
- Package cv32e40px_popcnt_pkg:
  - function clog2-based level count;
  - function stage_after_level(PIPE_STAGES, L) for register placement;
  - typedef of the sideband struct {valid, accum, last}.
- Sub-module cv32e40px_popcnt_level (params IN_W, N_IN): one tree level of pairwise adders, purely combinational. The top instantiates it L times and inserts registers per the package function.

Test Plan:
- Single beats, WIDTH=32, PIPE_STAGES=2, ready_i=1. Send 0xFFFFFFFF, 0x00000000, 0x80000001 back-to-back → results 32, 0, 2 on consecutive cycles, first at t+3.
- Group: accum=1 with 0x0000000F, 0x000000FF, then last with 0xFFFF0000 → one output of 28, overflow 0. There is no valid_o on the first two beats.
- Saturation, ACC_WIDTH=6: group of 0xFFFFFFFF, then 0xFFFFFFFF with last → result 63, overflow 1. The next group of 0x1 with last → result 1, overflow 0.
- Backpressure: ready_i=0 for 4 cycles while 5 beats are streamed. ready_o drops after the output fills, and result_o is held. After release, all 5 results appear in order with no loss or duplication.
- Interleave: a group beat 0xF (accum=1), then a single beat 0x3, then a group last beat 0x1 → outputs 2, then 5.
- Reset mid-group and pipe: rst pulsed with 2 beats in flight and acc=12. Then a new single beat 0x7 → only output is 3, with no stale result. Repeat with PIPE_STAGES=0 (latency 1) and WIDTH=8.
